// File: rtl/mul_arb_pkg.sv
// Shared types and defaults for the two-requester shift-add multiplier arbiter.
package mul_arb_pkg;

   localparam int unsigned SIZE_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: one partial product per clock, SIZE steps per operation.
module mul_seq
   import mul_arb_pkg::*;
#(
   parameter int unsigned SIZE = SIZE_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SIZE-1:0]     a,
   input  logic [SIZE-1:0]     b,
   output logic                done,
   output logic [2*SIZE-1:0]   product
);

   localparam int unsigned CW = $clog2(SIZE + 1);

   logic [2*SIZE-1:0] a_q, a_d;
   logic [2*SIZE-1:0] acc_q, acc_d;
   logic [SIZE-1:0]   b_q, b_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              done_q, done_d;

   // Load on start, otherwise step while the bit counter is non-zero.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (start) begin
         a_d   = {{SIZE{1'b0}}, a};
         b_d   = b;
         acc_d = {(2*SIZE){1'b0}};
         cnt_d = CW'(SIZE);
      end else if (cnt_q != {CW{1'b0}}) begin
         if (b_q[0]) begin
            acc_d = acc_q + a_q;
         end else begin
            acc_d = acc_q;
         end
         a_d    = a_q << 1;
         b_d    = b_q >> 1;
         cnt_d  = cnt_q - CW'(1);
         done_d = (cnt_q == CW'(1));
      end else begin
         done_d = 1'b0;
      end
   end

   // Datapath state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= {(2*SIZE){1'b0}};
         b_q    <= {SIZE{1'b0}};
         acc_q  <= {(2*SIZE){1'b0}};
         cnt_q  <= {CW{1'b0}};
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done    = done_q;
   assign product = acc_q;

endmodule

// File: rtl/mul_arb.sv
// Arbitrates two requesters onto one mul_seq and holds each product until taken.
// Define MUL_ARB_RR_EN for round-robin ties; otherwise requester 0 wins ties.
module mul_arb
   import mul_arb_pkg::*;
#(
   parameter int unsigned SIZE = SIZE_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   input  logic [SIZE-1:0]     req0_a,
   input  logic [SIZE-1:0]     req0_b,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [SIZE-1:0]     req1_a,
   input  logic [SIZE-1:0]     req1_b,
   output logic                req1_ready,
   output logic                rsp_valid,
   output logic                rsp_id,
   output logic [2*SIZE-1:0]   rsp_result,
   input  logic                rsp_ready,
   output logic                busy
);

   state_e            state_q, state_d;
   logic              grant_s, tie_s, accept_s;
   logic              id_q, id_d;
   logic              rsp_id_q, rsp_id_d;
   logic [2*SIZE-1:0] result_q, result_d;
   logic              rsp_valid_q, busy_q;
   logic              seq_done_s;
   logic [2*SIZE-1:0] seq_product_s;

`ifdef MUL_ARB_RR_EN
   logic prio_q;

   // Tie priority moves away from whichever requester was just granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else if (accept_s) begin
         prio_q <= ~grant_s;
      end else begin
         prio_q <= prio_q;
      end
   end

   assign tie_s = prio_q;
`else
   assign tie_s = 1'b0;
`endif

   // Grant selection among the valid requesters.
   always_comb begin
      if (req0_valid && req1_valid) begin
         grant_s = tie_s;
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // FSM next state, capture of grant id and completed product.
   always_comb begin
      state_d  = state_q;
      accept_s = 1'b0;
      id_d     = id_q;
      rsp_id_d = rsp_id_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               accept_s = 1'b1;
               id_d     = grant_s;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            if (seq_done_s) begin
               result_d = seq_product_s;
               rsp_id_d = id_q;
               state_d  = DONE;
            end else begin
               state_d  = RUN;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         id_q        <= 1'b0;
         rsp_id_q    <= 1'b0;
         result_q    <= {(2*SIZE){1'b0}};
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         rsp_id_q    <= rsp_id_d;
         result_q    <= result_d;
         rsp_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
      end
   end

   mul_seq #(.SIZE(SIZE)) u_seq (
      .clk     (clk),
      .rst     (rst),
      .start   (accept_s),
      .a       (grant_s ? req1_a : req0_a),
      .b       (grant_s ? req1_b : req0_b),
      .done    (seq_done_s),
      .product (seq_product_s)
   );

   // Ready is masked by rst so it drops the moment reset asserts.
   assign req0_ready = accept_s & ~grant_s & ~rst;
   assign req1_ready = accept_s &  grant_s & ~rst;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = result_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb (SIZE=8): directed table, tie/backpressure/reset sequences, random ops.
module tb_mul_arb;

   localparam int SIZE = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req1_valid, req0_ready, req1_ready;
   logic [SIZE-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic              rsp_valid, rsp_id, rsp_ready, busy;
   logic [2*SIZE-1:0] rsp_result;

   int   n_checks = 0;
   int   n_err    = 0;
   logic last_grant;

   mul_arb #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v0;
      logic [7:0]  a0, b0;
      logic        v1;
      logic [7:0]  a1, b1;
      logic        id;
      logic [15:0] res;
      int          hold;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration: a lone valid wins; ties follow the configured rule.
   function automatic logic model_pick(input logic v0, input logic v1);
      if (v0 && v1) begin
`ifdef MUL_ARB_RR_EN
         return !last_grant;
`else
         return 1'b0;
`endif
      end
      return v1 && !v0;
   endfunction

   task automatic run_op(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic exp_id, input logic [15:0] exp_res,
                         input int hold, input string tag);
      int lat;
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      rsp_ready  = 1'b0;
      #1;
      chk({tag, ".ready0"}, req0_ready, exp_id == 1'b0);
      chk({tag, ".ready1"}, req1_ready, exp_id == 1'b1);
      tick();
      last_grant = exp_id;
      // Drop valids, scramble operands, and poke rsp_ready while nothing is valid.
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      rsp_ready = 1'b1;
      chk({tag, ".busy_run"}, busy, 1'b1);
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      rsp_ready = 1'b0;
      chk({tag, ".latency"}, lat, 9);
      chk({tag, ".id"}, rsp_id, exp_id);
      chk({tag, ".result"}, rsp_result, exp_res);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, ".hold_valid"}, rsp_valid, 1'b1);
         chk({tag, ".hold_result"}, rsp_result, exp_res);
         chk({tag, ".hold_id"}, rsp_id, exp_id);
         chk({tag, ".hold_ready"}, {req0_ready, req1_ready}, 2'b00);
      end
      rsp_ready = 1'b1;
      #1;
      chk({tag, ".retire_ready"}, {req0_ready, req1_ready}, 2'b00);
      tick();
      chk({tag, ".idle_busy"}, busy, 1'b0);
      chk({tag, ".idle_valid"}, rsp_valid, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1'b1, 8'd13,  8'd11,  1'b0, 8'd0,   8'd0,   1'b0, 16'd143,   0};
      tbl[1] = '{1'b1, 8'd255, 8'd255, 1'b0, 8'd0,   8'd0,   1'b0, 16'd65025, 5};
      tbl[2] = '{1'b1, 8'd0,   8'd200, 1'b0, 8'd0,   8'd0,   1'b0, 16'd0,     1};
      tbl[3] = '{1'b1, 8'd1,   8'd128, 1'b0, 8'd0,   8'd0,   1'b0, 16'd128,   2};
      tbl[4] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd7,   8'd9,   1'b1, 16'd63,    0};
      tbl[5] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd255, 8'd1,   1'b1, 16'd255,   1};
      tbl[6] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd200, 8'd0,   1'b1, 16'd0,     0};

      rst = 1'b1; rsp_ready = 1'b0; last_grant = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
      #2;
      chk("reset.outputs", {rsp_valid, rsp_id, busy, req0_ready, req1_ready}, 5'b0);
      chk("reset.result", rsp_result, 16'd0);
      tick(); tick();
      chk("reset.held", {rsp_valid, busy, req0_ready, req1_ready}, 4'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("reset.release_busy", busy, 1'b0);

      // Both requesters held valid: alternate under round-robin, always 0 otherwise.
      for (int k = 0; k < 4; k++) begin
         logic      e;
         logic [7:0] x0, x1;
         x0 = 8'(k + 1); x1 = 8'(k + 10);
         e  = model_pick(1'b1, 1'b1);
         run_op(1'b1, x0, 8'd3, 1'b1, x1, 8'd7, e,
                e ? 16'(int'(x1) * 7) : 16'(int'(x0) * 3), k % 3, "tie");
      end

      for (int i = 0; i < 7; i++) begin
         run_op(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1,
                tbl[i].id, tbl[i].res, tbl[i].hold, $sformatf("tbl%0d", i));
      end

      for (int i = 0; i < 30; i++) begin
         logic       v0, v1, e;
         logic [7:0] a0, b0, a1, b1;
         int         p;
         v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
         e  = model_pick(v0, v1);
         p  = e ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
         run_op(v0, a0, b0, v1, a1, b1, e, 16'(p), int'($urandom_range(0, 3)),
                $sformatf("rnd%0d", i));
      end

      // Abort an operation from requester 1 on its fourth RUN cycle.
      req1_valid = 1'b1; req1_a = 8'd200; req1_b = 8'd200;
      #1;
      tick();
      tick(); tick(); tick();
      #3;
      rst = 1'b1;
      #1;
      chk("abort.outputs", {rsp_valid, rsp_id, busy, req0_ready, req1_ready}, 5'b0);
      chk("abort.result", rsp_result, 16'd0);
      req1_valid = 1'b0;
      last_grant = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      chk("abort.discarded", {rsp_valid, busy}, 2'b00);
      run_op(1'b1, 8'd3, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0, 16'd15, 1, "post_rst");
      begin
         logic e;
         e = model_pick(1'b1, 1'b1);
         run_op(1'b1, 8'd6, 8'd6, 1'b1, 8'd9, 8'd9, e, e ? 16'd81 : 16'd36, 0, "post_rst_tie");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
